// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, frame constants and the
// default bit period used by both the receive and transmit paths.
package uart_pkg;

    localparam int DATA_BITS        = 8;
    localparam int BAUD_DIV_DEFAULT = 5208;
    localparam int BAUD_DIV_MIN     = 4;
    localparam int BAUD_DIV_MAX     = 8191;
    localparam int CNT_W            = 13;

    typedef enum logic [2:0] {
        RX_IDLE       = 3'd0,
        RX_START      = 3'd1,
        RX_DATA       = 3'd2,
        RX_STOP       = 3'd3,
        RX_BREAK_WAIT = 3'd4
    } rx_state_e;

    // Count value at which the start bit is re-checked (middle of the bit).
    function automatic int half_bit_tc(input int baud_div);
        return baud_div / 2 - 1;
    endfunction

    function automatic int full_bit_tc(input int baud_div);
        return baud_div - 1;
    endfunction

endpackage

// File: rtl/rx_baud_cnt.sv
// Bit-period counter for the UART receiver. Counts clock cycles since the
// last clear and flags the half-bit and full-bit sample points.
module rx_baud_cnt
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk_50M,
    input  logic reset,
    input  logic clear,
    output logic half_tc,
    output logic full_tc
);

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(half_bit_tc(BAUD_DIV));
    localparam logic [CNT_W-1:0] FULL_TC = CNT_W'(full_bit_tc(BAUD_DIV));

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk_50M) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count != FULL_TC) begin
            // Saturate at the full-bit point so a missed clear never wraps.
            count <= count + 1'b1;
        end
    end

    assign half_tc = (count == HALF_TC);
    assign full_tc = (count == FULL_TC);

endmodule

// File: rtl/uart_rxd_ctrl.sv
// UART receiver, 8N1: synchronizes the serial line, frames bytes with a
// mid-bit sampling FSM and reports good frames and framing errors as pulses.
module uart_rxd_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] read_value,
    output logic       read_complete,
    output logic       read_error,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e state;
    rx_state_e state_next;

    logic       rxd_meta;
    logic       rxd_s;
    logic       rxd_prev;
    logic [7:0] shift_reg;
    logic [2:0] bit_idx;

    logic cnt_clear;
    logic half_tc;
    logic full_tc;
    logic bit_clear;
    logic shift_en;
    logic load_value;
    logic frame_err;

    rx_baud_cnt #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_cnt (
        .clk_50M (clk_50M),
        .reset   (reset),
        .clear   (cnt_clear),
        .half_tc (half_tc),
        .full_tc (full_tc)
    );

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state <= RX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a signal unassigned (no latches).
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        bit_clear  = 1'b0;
        shift_en   = 1'b0;
        load_value = 1'b0;
        frame_err  = 1'b0;

        unique case (state)
            RX_IDLE: begin
                cnt_clear = 1'b1;
                if (rxd_prev && !rxd_s) begin
                    state_next = RX_START;
                    bit_clear  = 1'b1;
                end
            end
            RX_START: begin
                if (half_tc) begin
                    cnt_clear  = 1'b1;
                    // A line that is high again mid-start-bit was a glitch.
                    state_next = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_tc) begin
                    cnt_clear = 1'b1;
                    shift_en  = 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (full_tc) begin
                    cnt_clear = 1'b1;
                    if (rxd_s) begin
                        load_value = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        frame_err  = 1'b1;
                        state_next = RX_BREAK_WAIT;
                    end
                end
            end
            RX_BREAK_WAIT: begin
                cnt_clear = 1'b1;
                if (rxd_s) begin
                    state_next = RX_IDLE;
                end
            end
            default: begin
                cnt_clear  = 1'b1;
                state_next = RX_IDLE;
            end
        endcase
    end

    // Synchronizer flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            rxd_meta      <= 1'b1;
            rxd_s         <= 1'b1;
            rxd_prev      <= 1'b1;
            shift_reg     <= 8'h00;
            bit_idx       <= 3'd0;
            read_value    <= 8'h00;
            read_complete <= 1'b0;
            read_error    <= 1'b0;
        end else begin
            rxd_meta      <= uart_rxd;
            rxd_s         <= rxd_meta;
            rxd_prev      <= rxd_s;
            read_complete <= load_value;
            read_error    <= frame_err;

            if (bit_clear) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end

            if (shift_en) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
            end

            if (load_value) begin
                read_value <= shift_reg;
            end
        end
    end

    assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rxd_ctrl.sv
// Self-checking bench for uart_rxd_ctrl: drives serial frames and compares
// the reported pulses against a frame-level reference model.
module tb_uart_rxd_ctrl;

    localparam int DIV = 16;

    typedef struct packed {
        logic       err;
        logic [7:0] value;
    } ev_t;

    logic       clk_50M = 1'b0;
    logic       reset   = 1'b1;
    logic       uart_rxd = 1'b1;
    logic [7:0] read_value;
    logic       read_complete;
    logic       read_error;
    logic       busy;

    ev_t        ev_q[$];
    ev_t        exp_q[$];
    int         overlap = 0;
    logic [7:0] model_value = 8'h00;
    int         checks = 0;
    int         errors = 0;

    uart_rxd_ctrl #(
        .BAUD_DIV (DIV)
    ) dut (
        .clk_50M       (clk_50M),
        .reset         (reset),
        .uart_rxd      (uart_rxd),
        .read_value    (read_value),
        .read_complete (read_complete),
        .read_error    (read_error),
        .busy          (busy)
    );

    always #5 clk_50M = ~clk_50M;

    // Every high cycle of a pulse is one observed event.
    always @(negedge clk_50M) begin
        if (!reset) begin
            if (read_complete && read_error) overlap++;
            if (read_complete) ev_q.push_back({1'b0, read_value});
            if (read_error)    ev_q.push_back({1'b1, read_value});
        end
    end

    // Reference model: a frame with a good stop bit delivers its byte; a bad
    // stop bit reports an error and leaves the last good byte in place.
    task automatic expect_frame(input logic [7:0] data, input logic stop);
        if (stop) begin
            model_value = data;
            exp_q.push_back({1'b0, data});
        end else begin
            exp_q.push_back({1'b1, model_value});
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        repeat (DIV) @(negedge clk_50M);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk_50M);
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_50M);
        checks += 4;
        if (read_value !== 8'h00) begin errors++; $display("FAIL reset_value: got %h, required 00", read_value); end
        if (read_complete !== 1'b0) begin errors++; $display("FAIL reset_complete: got %b, required 0", read_complete); end
        if (read_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b, required 0", read_error); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        reset = 1'b0;
        repeat (4) @(negedge clk_50M);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b, required 0", busy); end
    endtask

    task automatic test_good_frame;
        send_frame(8'hA5, 1'b1);
        expect_frame(8'hA5, 1'b1);
        uart_rxd = 1'b1;
        wait_idle("good");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL good_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL good_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        checks += 2;
        if (read_value !== 8'hA5) begin errors++; $display("FAIL good_value: got %h, required a5", read_value); end
        if (overlap != 0) begin errors++; $display("FAIL good_overlap: got %0d, required 0", overlap); end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_glitch;
        int n;
        uart_rxd = 1'b0;
        repeat (3) @(negedge clk_50M);
        uart_rxd = 1'b1;
        n = 3;
        while (!busy && n < 8) begin @(negedge clk_50M); n++; end
        checks++;
        if (!busy) begin errors++; $display("FAIL glitch_busy_rise: got busy=%b, required 1", busy); end
        n = 0;
        while (busy && n < 10) begin @(negedge clk_50M); n++; end
        checks++;
        if (busy) begin errors++; $display("FAIL glitch_busy_fall: busy still %b after %0d cycles, required 0 within 9", busy, n); end
        repeat (2 * DIV) @(negedge clk_50M);
        checks += 2;
        if (ev_q.size() != 0) begin errors++; $display("FAIL glitch_events: got %0d, required 0", ev_q.size()); end
        if (read_value !== model_value) begin errors++; $display("FAIL glitch_value: got %h, required %h", read_value, model_value); end
        ev_q.delete();
    endtask

    task automatic test_framing_error;
        send_frame(8'h3C, 1'b0);
        expect_frame(8'h3C, 1'b0);
        uart_rxd = 1'b1;
        wait_idle("framing");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL framing_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL framing_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        checks++;
        if (read_value !== 8'hA5) begin errors++; $display("FAIL framing_value: got %h, required a5", read_value); end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        expect_frame(8'h00, 1'b1);
        expect_frame(8'hFF, 1'b1);
        uart_rxd = 1'b1;
        wait_idle("b2b");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] aborted;
        aborted = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(aborted[i]);
        uart_rxd = aborted[4];
        repeat (DIV / 2) @(negedge clk_50M);
        reset    = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk_50M);
        reset       = 1'b0;
        model_value = 8'h00;
        checks += 2;
        if (read_value !== 8'h00) begin errors++; $display("FAIL midreset_value: got %h, required 00", read_value); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, required 0", busy); end
        repeat (2 * DIV) @(negedge clk_50M);
        send_frame(8'h81, 1'b1);
        expect_frame(8'h81, 1'b1);
        uart_rxd = 1'b1;
        wait_idle("midreset");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL midreset_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_break;
        uart_rxd = 1'b0;
        repeat (20 * DIV) @(negedge clk_50M);
        expect_frame(8'h00, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL break_busy: got %b, required 1", busy); end
        uart_rxd = 1'b1;
        wait_idle("break");
        repeat (2 * DIV) @(negedge clk_50M);
        send_frame(8'h55, 1'b1);
        expect_frame(8'h55, 1'b1);
        uart_rxd = 1'b1;
        wait_idle("break_next");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL break_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL break_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        ev_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        logic [7:0] d;
        logic       stop;
        int         gap;
        for (int f = 0; f < 16; f++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            send_frame(d, stop);
            expect_frame(d, stop);
            gap = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            uart_rxd = 1'b1;
            repeat (gap * DIV) @(negedge clk_50M);
        end
        uart_rxd = 1'b1;
        wait_idle("random");
        repeat (DIV) @(negedge clk_50M);
        checks++;
        if (ev_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d events, required %0d", ev_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (ev_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random_event%0d: got err=%b val=%h, required err=%b val=%h",
                             i, ev_q[i].err, ev_q[i].value, exp_q[i].err, exp_q[i].value);
                end
            end
        end
        checks += 2;
        if (read_value !== model_value) begin errors++; $display("FAIL random_value: got %h, required %h", read_value, model_value); end
        if (overlap != 0) begin errors++; $display("FAIL random_overlap: got %0d, required 0", overlap); end
        ev_q.delete();
        exp_q.delete();
    endtask

    initial begin
        @(negedge clk_50M);
        test_reset();
        test_good_frame();
        test_glitch();
        test_framing_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rxd_ctrl.md
UART_RXD_CTRL -- requirements
Module: uart_rxd_ctrl

Interface
REQ-001 Parameter BAUD_DIV, default 5208, meaning clk_50M cycles per bit (9600 baud at 50 MHz); legal range 4..8191.
REQ-002 Port clk_50M  input  1  system clock; all logic on rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port uart_rxd  input  1  asynchronous serial line; idle high.
REQ-005 Port read_value  output  8  last correctly framed byte.
REQ-006 Port read_complete  output  1  one-cycle pulse when a good frame is received.
REQ-007 Port read_error  output  1  one-cycle pulse on framing error.
REQ-008 Port busy  output  1  high while not in IDLE.

Function
REQ-009 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-010 uart_rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxd_s.
REQ-011 State machine SHALL have states IDLE, START, DATA, STOP, BREAK_WAIT.
REQ-012 IDLE: a falling edge on rxd_s (previous 1, current 0) SHALL enter START and clear the bit counter.
REQ-013 START: at count == BAUD_DIV/2 - 1 (integer division), rxd_s SHALL be sampled; 0 -> DATA with counter cleared; 1 -> IDLE, no pulse (glitch reject).
REQ-014 DATA: at count == BAUD_DIV - 1, rxd_s SHALL be shifted into bit 7 of the shift register (shift right) and the bit index incremented; after the 8th sample -> STOP.
REQ-015 STOP: at count == BAUD_DIV - 1, rxd_s SHALL be sampled; 1 -> IDLE; 0 -> BREAK_WAIT.
REQ-016 On a good stop sample, read_value SHALL load the shift register and read_complete SHALL be high for exactly the following cycle, read_value valid in that same cycle.
REQ-017 On a bad stop sample, read_error SHALL be high for exactly the following cycle and read_value SHALL keep its prior value.
REQ-018 BREAK_WAIT SHALL remain until rxd_s == 1, then enter IDLE; no further pulses while the line stays low.
REQ-019 read_complete and read_error SHALL never be high in the same cycle.
REQ-020 The bit counter SHALL clear on every sample point and on every state entry; it SHALL not wrap during a bit.
REQ-021 Return to IDLE after the stop sample (mid-stop-bit) SHALL allow a following start edge to be accepted with zero idle time between frames.
REQ-022 read_value SHALL hold between frames and change only per REQ-016.

Reset
REQ-023 With reset high at a clock edge: state = IDLE, counter = 0, bit index = 0, shift register = 0x00, read_value = 0x00, read_complete = 0, read_error = 0, busy = 0, synchronizer flops = 1.
REQ-024 Reset mid-frame SHALL abort the frame with no pulse; the first falling edge after reset deasserts starts a new frame.

Structure
REQ-025 Shared package uart_pkg SHALL hold the rx state enum, the frame constants (DATA_BITS = 8), and the default BAUD_DIV shared with the transmit path.
REQ-026 One sub-module rx_baud_cnt SHALL implement the bit counter with clear input and half-bit/full-bit terminal-count outputs; the FSM, shifter and synchronizer stay in uart_rxd_ctrl.

Verification (bench with BAUD_DIV = 16)
REQ-027 Frame 0xA5, stop = 1 -> one read_complete pulse, read_value = 0xA5, read_error stays 0.
REQ-028 uart_rxd low for 3 cycles then high -> no pulses, busy returns to 0 within 8 cycles of the start edge, read_value unchanged.
REQ-029 After 0xA5, send frame 0x3C with stop = 0 -> one read_error pulse, read_value stays 0xA5, no read_complete.
REQ-030 Frames 0x00 then 0xFF back-to-back with no idle bits -> two read_complete pulses, read_value 0x00 then 0xFF.
REQ-031 Assert reset during data bit 4 of a frame, then send 0x81 -> no pulse for the aborted frame; one read_complete with read_value = 0x81.
REQ-032 Hold uart_rxd low for 20 bit times, then high, then send 0x55 -> exactly one read_error; then one read_complete with read_value = 0x55.
